// File: rtl/btop_bank_ram_if.sv
// Bus bundle for the banked LLR/partial-sum RAM: clear, masked multi-segment
// write port, single-segment read port and status outputs.
interface btop_bank_ram_if #(
  parameter int AW    = 5,
  parameter int SEGS  = 2,
  parameter int LANES = 16,
  parameter int W     = 768,
  parameter int SW    = 1
);
  logic                  clr;
  logic                  w_en;
  logic [AW-1:0]         cnta;
  logic [SEGS*LANES-1:0] w_mask;
  logic [SEGS*W-1:0]     b_in;
  logic                  r_en;
  logic [AW-1:0]         cntb;
  logic [SW-1:0]         rseg;
  logic [W-1:0]          b_out;
  logic                  r_valid;
  logic                  err;

  modport master (
    output clr, w_en, cnta, w_mask, b_in, r_en, cntb, rseg,
    input  b_out, r_valid, err
  );

  modport slave (
    input  clr, w_en, cnta, w_mask, b_in, r_en, cntb, rseg,
    output b_out, r_valid, err
  );
endinterface

// File: rtl/btop_bank_ram.sv
// Banked word RAM: SEGS segments written in parallel under a lane-group mask,
// one segment read per cycle with write-first bypass and a sticky range error.
module btop_bank_ram #(
  parameter int N     = 1024,
  parameter int P     = 128,
  parameter int Q     = 6,
  parameter int SEGS  = 2,
  parameter int LANES = 16,
  parameter int DEPTH = N / (4 * P),
  parameter int AW    = 5
) (
  input  logic              clk,
  input  logic              rst,
  btop_bank_ram_if.slave    bus
);
  localparam int W  = P * Q;
  localparam int LW = W / LANES;
  localparam int SW = (SEGS > 1) ? $clog2(SEGS) : 1;

  logic [W-1:0]  r_mem [SEGS][DEPTH];
  logic [W-1:0]  r_rdata_p1;
  logic          r_vld_p1;
  logic          r_err;

  logic [SW-1:0] w_rseg;
  logic          w_wr_in_rng;
  logic          w_wr_ok;
  logic          w_rd_ok;
  logic [W-1:0]  w_rd_word;
  logic [W-1:0]  w_rd_data;

  assign w_rseg      = bus.rseg;
  assign w_wr_in_rng = 32'(bus.cnta) < DEPTH;
  assign w_wr_ok     = bus.w_en && w_wr_in_rng;
  assign w_rd_ok     = (32'(bus.cntb) < DEPTH) && (32'(w_rseg) < SEGS);

  // Read mux, then overlay groups being written to the same word this cycle
  always_comb begin
    w_rd_word = '0;
    for (int s = 0; s < SEGS; s++) begin
      for (int a = 0; a < DEPTH; a++) begin
        if (32'(w_rseg) == s && 32'(bus.cntb) == a) w_rd_word = r_mem[s][a];
      end
    end
    w_rd_data = w_rd_word;
    for (int s = 0; s < SEGS; s++) begin
      for (int k = 0; k < LANES; k++) begin
        if (w_wr_ok && bus.cnta == bus.cntb && 32'(w_rseg) == s &&
            bus.w_mask[s*LANES+k])
          w_rd_data[k*LW +: LW] = bus.b_in[s*W + k*LW +: LW];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < SEGS; s++)
        for (int a = 0; a < DEPTH; a++)
          r_mem[s][a] <= '0;
    end else if (bus.clr) begin
      for (int s = 0; s < SEGS; s++)
        for (int a = 0; a < DEPTH; a++)
          r_mem[s][a] <= '0;
    end else if (w_wr_ok) begin
      for (int s = 0; s < SEGS; s++)
        for (int a = 0; a < DEPTH; a++)
          for (int k = 0; k < LANES; k++)
            if (32'(bus.cnta) == a && bus.w_mask[s*LANES+k])
              r_mem[s][a][k*LW +: LW] <= bus.b_in[s*W + k*LW +: LW];
    end
  end

  // ---- stage p1: registered read result ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdata_p1 <= '0;
      r_vld_p1   <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_vld_p1   <= bus.r_en;
      r_rdata_p1 <= (bus.r_en && w_rd_ok && !bus.clr) ? w_rd_data : '0;
      if ((bus.w_en && !w_wr_in_rng) || (bus.r_en && !w_rd_ok))
        r_err <= 1'b1;
    end
  end

  assign bus.b_out   = r_rdata_p1;
  assign bus.r_valid = r_vld_p1;
  assign bus.err     = r_err;
endmodule

// File: tb/tb_btop_bank_ram.sv
// Directed bench for btop_bank_ram at default parameters (W=768, LW=48,
// SEGS=2, DEPTH=2); expected words are hand-built patterns.
module tb_btop_bank_ram;
  localparam int W = 768;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  btop_bank_ram_if #(.AW(5), .SEGS(2), .LANES(16), .W(W), .SW(1)) bus ();

  btop_bank_ram u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] pA5, p5A, p3C, pC3, ones, exp_w;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $display("FAIL %s: observed %h required %h", tag, obs, expv);
      $error("check %s did not hold", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.clr = 1'b0; bus.w_en = 1'b0; bus.cnta = '0; bus.w_mask = '0;
    bus.b_in = '0;  bus.r_en = 1'b0; bus.cntb = '0; bus.rseg = '0;
  endtask

  task automatic rd(input int a, input int s);
    bus.w_en = 1'b0; bus.r_en = 1'b1;
    bus.cntb = 5'(a); bus.rseg = 1'(s);
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    pA5  = {96{8'hA5}};
    p5A  = {96{8'h5A}};
    p3C  = {96{8'h3C}};
    pC3  = {96{8'hC3}};
    ones = '1;
    idle();
    rst = 1'b0;
    #2;
    check("rst_b_out", bus.b_out, '0);
    check("rst_r_valid", W'(bus.r_valid), '0);
    check("rst_err", W'(bus.err), '0);
    @(negedge clk);
    rst = 1'b1;

    // Full-mask write of word 1, both segments, then read each back
    bus.w_en = 1'b1; bus.cnta = 5'd1; bus.w_mask = '1; bus.b_in = {p5A, pA5};
    tick();
    rd(1, 0);
    check("rd_w1_s0", bus.b_out, pA5);
    check("rd_w1_s0_vld", W'(bus.r_valid), W'(1));
    rd(1, 1);
    check("rd_w1_s1", bus.b_out, p5A);
    check("rd_w1_s1_vld", W'(bus.r_valid), W'(1));

    // Word 0 all ones, then clear only segment 0 group 0
    idle();
    bus.w_en = 1'b1; bus.cnta = 5'd0; bus.w_mask = '1; bus.b_in = {ones, ones};
    tick();
    check("idle_b_out", bus.b_out, '0);
    check("idle_vld", W'(bus.r_valid), '0);
    bus.w_mask = 32'h0000_0001; bus.b_in = '0;
    tick();
    rd(0, 0);
    exp_w = ones; exp_w[47:0] = '0;
    check("mask_g0_s0", bus.b_out, exp_w);
    rd(0, 1);
    check("mask_s1_kept", bus.b_out, ones);
    rd(1, 0);
    check("mask_w1_kept", bus.b_out, pA5);

    // Write-first: full segment-0 write and read of the same word
    idle();
    bus.w_en = 1'b1; bus.cnta = 5'd0; bus.w_mask = 32'h0000_FFFF; bus.b_in = {ones, p3C};
    bus.r_en = 1'b1; bus.cntb = 5'd0; bus.rseg = 1'b0;
    tick();
    check("wf_full", bus.b_out, p3C);
    // Partial write-first: group 1 new (zero), rest stored
    bus.w_mask = 32'h0000_0002; bus.b_in = '0;
    tick();
    exp_w = p3C; exp_w[95:48] = '0;
    check("wf_partial", bus.b_out, exp_w);
    idle();
    tick();
    check("ren0_b_out", bus.b_out, '0);
    check("ren0_vld", W'(bus.r_valid), '0);
    rd(0, 1);
    check("wf_s1_kept", bus.b_out, ones);

    // Write seg1 word1 while reading seg0 word1 in the same cycle
    idle();
    bus.w_en = 1'b1; bus.cnta = 5'd1; bus.w_mask = 32'hFFFF_0000; bus.b_in = {pC3, ones};
    bus.r_en = 1'b1; bus.cntb = 5'd1; bus.rseg = 1'b0;
    tick();
    check("par_rd_s0w1", bus.b_out, pA5);
    rd(1, 1);
    check("par_wr_s1w1", bus.b_out, pC3);
    check("no_err_yet", W'(bus.err), '0);

    // Out-of-range write then read
    idle();
    bus.w_en = 1'b1; bus.cnta = 5'd3; bus.w_mask = '1; bus.b_in = {ones, ones};
    tick();
    check("oor_wr_err", W'(bus.err), W'(1));
    rd(2, 0);
    check("oor_rd_data", bus.b_out, '0);
    check("oor_rd_vld", W'(bus.r_valid), W'(1));
    check("oor_rd_err", W'(bus.err), W'(1));
    rd(1, 0);
    check("oor_no_alias", bus.b_out, pA5);

    // Clear with simultaneous write and read of word 1
    idle();
    bus.clr = 1'b1; bus.w_en = 1'b1; bus.cnta = 5'd1; bus.w_mask = '1; bus.b_in = {ones, ones};
    bus.r_en = 1'b1; bus.cntb = 5'd1; bus.rseg = 1'b0;
    tick();
    check("clr_rd", bus.b_out, '0);
    check("clr_rd_vld", W'(bus.r_valid), W'(1));
    check("clr_err_sticky", W'(bus.err), W'(1));
    bus.clr = 1'b0;
    for (int a = 0; a < 2; a++)
      for (int s = 0; s < 2; s++) begin
        rd(a, s);
        check($sformatf("clr_after_w%0d_s%0d", a, s), bus.b_out, '0);
      end

    // Asynchronous reset in the middle of a valid read
    idle();
    bus.w_en = 1'b1; bus.cnta = 5'd0; bus.w_mask = '1; bus.b_in = {p5A, pA5};
    tick();
    rd(0, 0);
    check("pre_rst_rd", bus.b_out, pA5);
    check("pre_rst_err", W'(bus.err), W'(1));
    #3;
    rst = 1'b0;
    #1;
    check("arst_b_out", bus.b_out, '0);
    check("arst_vld", W'(bus.r_valid), '0);
    check("arst_err", W'(bus.err), '0);
    @(negedge clk);
    rst = 1'b1;
    for (int a = 0; a < 2; a++)
      for (int s = 0; s < 2; s++) begin
        rd(a, s);
        check($sformatf("post_rst_w%0d_s%0d", a, s), bus.b_out, '0);
      end
    check("post_rst_err", W'(bus.err), '0);
    rd(2, 1);
    check("rd_oor_err", W'(bus.err), W'(1));
    check("rd_oor_vld", W'(bus.r_valid), W'(1));

    idle();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/btop_bank_ram.md
BTOP_BANK_RAM -- requirements
Module: btop_bank_ram

Interface
REQ-001 Parameter N, default 1024, code length.
REQ-002 Parameter P, default 128, LLR/partial-sum lanes per word.
REQ-003 Parameter Q, default 6, bits per lane.
REQ-004 Parameter SEGS, default 2, segments written in parallel per write.
REQ-005 Parameter LANES, default 16, write-mask granularity; P*Q SHALL be divisible by LANES.
REQ-006 Parameter DEPTH, default N/(4*P), words per segment.
REQ-007 Parameter AW, default 5, address width.
REQ-008 Derived constants: W = P*Q word width; LW = W/LANES lane-group width; SW = max(1, clog2(SEGS)).
REQ-009 Ports, clock and reset first:
- clk  in  1  rising-edge clock, the only clock.
- rst  in  1  reset, asynchronous, active-low.
- clr  in  1  synchronous clear of all storage.
- w_en  in  1  write enable.
- cnta  in  AW  write word address, common to all segments.
- w_mask  in  SEGS*LANES  per-segment, per-lane-group write enable; bit s*LANES+k covers segment s, group k.
- b_in  in  SEGS*W  write data; segment s occupies bits [s*W +: W].
- r_en  in  1  read enable.
- cntb  in  AW  read word address.
- rseg  in  SW  read segment select.
- b_out  out  W  read data.
- r_valid  out  1  b_out holds data from an accepted read.
- err  out  1  sticky address/segment range error.

Function
REQ-010 Storage SHALL be SEGS x DEPTH words of W bits, with segment s, word a, group k mapped to bits [k*LW +: LW] of that word.
REQ-011 When w_en=1 and cnta<DEPTH, each group (s,k) with w_mask bit set SHALL be loaded from b_in[s*W + k*LW +: LW] at the clock edge; groups with a clear mask bit SHALL keep their contents.
REQ-012 A write with cnta>=DEPTH SHALL modify no storage and SHALL set err.
REQ-013 A read is accepted when r_en=1; read latency SHALL be one cycle: b_out and r_valid update on the edge that samples r_en.
REQ-014 For an accepted read with cntb<DEPTH and rseg<SEGS, b_out SHALL be word cntb of segment rseg and r_valid SHALL be 1.
REQ-015 For an accepted read with cntb>=DEPTH or rseg>=SEGS, b_out SHALL be 0, r_valid SHALL be 1, and err SHALL be set.
REQ-016 When r_en=0, b_out SHALL become 0 and r_valid SHALL become 0 on the next edge.
REQ-017 Read and write to the same segment and word in the same cycle SHALL be write-first: masked groups return the new b_in data, unmasked groups return the stored data.
REQ-018 When clr=1, all storage SHALL become 0 at the edge, and clr SHALL take priority over a simultaneous write.
REQ-019 A read accepted in the same cycle as clr SHALL return 0.
REQ-020 err SHALL be sticky until rst; clr SHALL NOT clear err.
REQ-021 Writes and reads to different addresses in the same cycle SHALL both complete with no stall; the block has no back-pressure.

Reset
REQ-022 While rst=0, independent of clk, storage, b_out, r_valid and err SHALL be 0.
REQ-023 Assertion of rst mid-read SHALL immediately force b_out=0 and r_valid=0.
REQ-024 The first edge after rst deasserts SHALL behave as a normal operating cycle.

Verification (defaults N=1024, P=128, Q=6, SEGS=2, DEPTH=2)
REQ-025 Write cnta=1, w_mask all ones, segment 0 = 0xA5 pattern, segment 1 = 0x5A; read cntb=1 rseg=0, then rseg=1 -> b_out is 0xA5 pattern then 0x5A, each one cycle after r_en, with r_valid=1.
REQ-026 Write word 0 with all ones, then rewrite it with w_mask=0x0001 (segment 0, group 0) and data 0 -> read segment 0 word 0 gives all ones except bits [47:0]=0; segment 1 is unchanged.
REQ-027 Same-cycle write and read to segment 0, word 0 with new data 0x3C pattern -> b_out equals 0x3C pattern on the next cycle (write-first); r_en=0 the following cycle -> b_out=0 and r_valid=0.
REQ-028 Write with cnta=3, then read with cntb=2 -> no storage change, b_out=0, r_valid=1, err=1; err stays 1 after clr and returns to 0 only after rst.
REQ-029 clr asserted together with w_en and r_en on word 1 -> the read returns 0 and all later reads return 0.
REQ-030 Drive rst=0 between clock edges during a valid read -> b_out=0, r_valid=0 and err=0 immediately; all words read back 0 after rst is released.
